// File: rtl/systolic_array_4x4.sv
// systolic_array_4x4: output-stationary 4x4 MAC array computing C = A x B from pre-skewed operand streams
module systolic_array_4x4 (
    input  logic [31:0]  inp_west0,
    input  logic [31:0]  inp_west4,
    input  logic [31:0]  inp_west8,
    input  logic [31:0]  inp_west12,
    input  logic [31:0]  inp_north0,
    input  logic [31:0]  inp_north1,
    input  logic [31:0]  inp_north2,
    input  logic [31:0]  inp_north3,
    input  logic         clk,
    input  logic         rst,
    output logic         done,
    output logic [511:0] result
);
    logic [3:0][31:0]  west, north;
    logic [15:0][31:0] w_in, n_in;
    logic [15:0][31:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    assign west  = {inp_west12, inp_west8, inp_west4, inp_west0};
    assign north = {inp_north3, inp_north2, inp_north1, inp_north0};
    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            if (j == 0) begin : g_w_edge
                assign w_in[4*i+j] = west[i];
            end else begin : g_w_hop
                assign w_in[4*i+j] = a_q[4*i+j-1];
            end
            if (i == 0) begin : g_n_edge
                assign n_in[4*i+j] = north[j];
            end else begin : g_n_hop
                assign n_in[4*i+j] = b_q[4*(i-1)+j];
            end
        end
    end
    always_comb begin
        a_d    = rst ? '0 : w_in;
        b_d    = rst ? '0 : n_in;
        acc_d  = acc_q;
        for (int k = 0; k < 16; k++)
            acc_d[k] = rst ? 32'd0 : acc_q[k] + w_in[k] * n_in[k];
        cnt_d  = rst ? 4'd0 : cnt_q + {3'd0, cnt_q != 4'd15};
        done_d = !rst && (done_q || cnt_q == 4'd9);
    end
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        acc_q  <= acc_d;
        cnt_q  <= cnt_d;
        done_q <= done_d;
    end
    assign done   = done_q;
    assign result = acc_q;
endmodule

// File: tb/tb_systolic_array_4x4.sv
// tb_systolic_array_4x4: directed checks of the 4x4 systolic array against hand values and a matmul model
module tb_systolic_array_4x4;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  w [4];
    logic [31:0]  n [4];
    logic         done;
    logic [511:0] res;
    logic [31:0]  a_m [4][4];
    logic [31:0]  b_m [4][4];
    logic [31:0]  e_m [4][4];
    int           checks = 0;
    int           failures = 0;

    systolic_array_4x4 dut (
        .inp_west0(w[0]), .inp_west4(w[1]), .inp_west8(w[2]), .inp_west12(w[3]),
        .inp_north0(n[0]), .inp_north1(n[1]), .inp_north2(n[2]), .inp_north3(n[3]),
        .clk(clk), .rst(rst), .done(done), .result(res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i, input int j);
        return res[32*(4*i+j) +: 32];
    endfunction

    task automatic drive(input int c);
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'd0;
            n[i] = 32'd0;
            if (c - i >= 0 && c - i < 4) begin
                w[i] = a_m[i][c-i];
                n[i] = b_m[c-i][i];
            end
        end
    endtask

    task automatic tick(input int c);
        drive(c);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'h0000_1230 + i;
            n[i] = 32'h0000_4560 + i;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                logic [31:0] s;
                s = 32'd0;
                for (int k = 0; k < 4; k++) s += a_m[i][k] * b_m[k][j];
                e_m[i][j] = s;
            end
    endtask

    task automatic check_mat(input string tag);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("%s_c%0d%0d", tag, i, j), lane(i, j), e_m[i][j]);
    endtask

    task automatic run_job(input string tag);
        for (int c = 0; c < 10; c++) begin
            tick(c);
            check($sformatf("%s_done_e%0d", tag, c), {31'd0, done}, 32'(c >= 9));
        end
        check_mat(tag);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 32'(4*i + 3 - k);
                b_m[i][k] = 32'(12 - 4*i + k);
            end
        model;
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'hffff;
            n[i] = 32'hffff;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", {31'd0, done}, 32'd0);
        for (int k = 0; k < 16; k++)
            check($sformatf("rst_lane%0d", k), res[32*k +: 32], 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(c);
            check($sformatf("ref_done_e%0d", c), {31'd0, done}, 32'(c >= 9));
            if (c == 3) check("ref_c00_e3", lane(0, 0), 32'd56);
            if (c == 8) check("ref_c33_e8", lane(3, 3), 32'd470);
        end
        check("ref_c00", lane(0, 0), 32'd56);
        check("ref_c03", lane(0, 3), 32'd74);
        check("ref_c30", lane(3, 0), 32'd344);
        check("ref_c33", lane(3, 3), 32'd506);
        check_mat("ref");
        for (int c = 0; c < 5; c++) tick(100);
        check("sticky_done", {31'd0, done}, 32'd1);
        check_mat("sticky");
        reset2;
        for (int c = 0; c < 5; c++) tick(c);
        rst = 1'b1;
        drive(5);
        @(posedge clk);
        @(negedge clk);
        check("abort_c00", lane(0, 0), 32'd0);
        check("abort_c11", lane(1, 1), 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        run_job("rerun");
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 32'(i == k);
                b_m[i][k] = 32'(4*i + k + 1);
                e_m[i][k] = 32'(4*i + k + 1);
            end
        reset2;
        run_job("ident");
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = 32'd0;
                b_m[i][k] = 32'd0;
                e_m[i][k] = 32'd0;
            end
        a_m[0][0] = 32'h0001_0000;
        b_m[0][0] = 32'h0001_0000;
        reset2;
        run_job("wrap");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
